// File: rtl/draw_pkg.sv
// draw_pkg: shared types and constants for the frame draw scheduler.
// Optional feature macro: DRAW_SCHED_CLEAR_EN (adds the play-field CLEAR state).
package draw_pkg;

   localparam int PLAY_W   = 40;
   localparam int PLAY_H   = 80;
   localparam int PIX_X_W  = 8;
   localparam int PIX_Y_W  = 7;
   localparam int COLOUR_W = 6;

   // Scheduler states; CLEAR only exists when the field blanking is built in.
   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
`ifdef DRAW_SCHED_CLEAR_EN
      S_CLEAR      = 3'd1,
`endif
      S_BOARD_KICK = 3'd2,
      S_BOARD      = 3'd3,
      S_PIECE      = 3'd4,
      S_FIN        = 3'd5
   } state_e;

   // Which source the plot port samples this cycle.
   typedef enum logic [1:0] {
      SRC_NONE  = 2'd0,
      SRC_CLEAR = 2'd1,
      SRC_BOARD = 2'd2,
      SRC_PIECE = 2'd3
   } src_e;

   typedef struct packed {
      logic [PIX_X_W-1:0]  x;
      logic [PIX_Y_W-1:0]  y;
      logic [COLOUR_W-1:0] colour;
   } pixel_t;

   function automatic pixel_t make_pixel(input logic [PIX_X_W-1:0]  x,
                                         input logic [PIX_Y_W-1:0]  y,
                                         input logic [COLOUR_W-1:0] colour);
      pixel_t p;
      p.x      = x;
      p.y      = y;
      p.colour = colour;
      return p;
   endfunction

endpackage

// File: rtl/draw_port_mux.sv
// draw_port_mux: registered 3-way select of clear / board / piece pixels onto
// the single VGA plot port. Coordinates and colour only update on a write so
// the port holds its last pixel while idle.
// Optional feature macro: DRAW_SCHED_CLEAR_EN (clear source is only selected
// when the scheduler is built with it).
module draw_port_mux
   import draw_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  src_e                sel,
   input  pixel_t              clear_pix,
   input  pixel_t              board_pix,
   input  pixel_t              piece_pix,
   input  logic                piece_write,
   output logic [PIX_X_W-1:0]  x,
   output logic [PIX_Y_W-1:0]  y,
   output logic [COLOUR_W-1:0] colour,
   output logic                write
);

   pixel_t pick;
   logic   wr;

   // Choose the source pixel and whether it is a real write.
   always_comb begin
      pick = board_pix;
      wr   = 1'b0;
      unique case (sel)
         SRC_CLEAR: begin pick = clear_pix; wr = 1'b1;        end
         SRC_BOARD: begin pick = board_pix; wr = 1'b1;        end
         SRC_PIECE: begin pick = piece_pix; wr = piece_write; end
         default:   ;
      endcase
   end

   // Register the port; pixel data is held whenever no write is issued.
   always_ff @(posedge clk) begin
      if (reset) begin
         x      <= '0;
         y      <= '0;
         colour <= '0;
         write  <= 1'b0;
      end else begin
         write <= wr;
         if (wr) begin
            x      <= pick.x;
            y      <= pick.y;
            colour <= pick.colour;
         end
      end
   end

endmodule

// File: rtl/draw_scheduler.sv
// draw_scheduler: per-frame sequencer sharing the VGA plot port between the
// board drawer and the falling-piece drawer. Sequence per start:
// [CLEAR] -> BOARD_KICK -> BOARD -> PIECE -> FIN (done pulse).
// Optional feature macro: DRAW_SCHED_CLEAR_EN blanks the play field first.
module draw_scheduler
   import draw_pkg::*;
#(
   parameter int BOARD_TIMEOUT = 4095,
   parameter int PIECE_CYCLES  = 64
)(
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                board_finished,
   input  logic [PIX_X_W-1:0]  board_X,
   input  logic [PIX_Y_W-1:0]  board_Y,
   input  logic [COLOUR_W-1:0] board_colour,
   input  logic [PIX_X_W-1:0]  piece_X,
   input  logic [PIX_Y_W-1:0]  piece_Y,
   input  logic [COLOUR_W-1:0] piece_colour,
   input  logic                piece_writeEn,
   output logic                board_enable,
   output logic                piece_run,
   output logic [PIX_X_W-1:0]  X,
   output logic [PIX_Y_W-1:0]  Y,
   output logic [COLOUR_W-1:0] colour,
   output logic                writeEn,
   output logic                busy,
   output logic                done,
   output logic                timeout
);

   localparam int              PC_W           = $clog2(PIECE_CYCLES + 1);
   localparam logic [11:0]     BOARD_LAST     = 12'(BOARD_TIMEOUT - 1);
   localparam logic [PC_W-1:0] PIECE_LAST     = PC_W'(PIECE_CYCLES);
   localparam logic [PC_W-1:0] PIECE_RUN_LAST = PC_W'(PIECE_CYCLES - 1);

   state_e          state, next_state;
   logic [11:0]     board_cnt;
   logic [PC_W-1:0] piece_cnt;
   logic            board_seen, board_to, board_exit;
   logic            board_enable_d, piece_run_d, busy_d, done_d, timeout_d;
   src_e            sel;
   pixel_t          clear_pix, board_pix, piece_pix;

`ifdef DRAW_SCHED_CLEAR_EN
   localparam logic [5:0] CLR_X_LAST = 6'(PLAY_W - 1);
   localparam logic [6:0] CLR_Y_LAST = 7'(PLAY_H - 1);

   logic [5:0] clr_x;
   logic [6:0] clr_y;
   logic       clr_last;

   assign clr_last  = (clr_x == CLR_X_LAST) && (clr_y == CLR_Y_LAST);
   assign clear_pix = make_pixel({2'b00, clr_x}, clr_y, '0);

   // Row-major field scan; parked at 0 outside CLEAR so each entry starts at (0,0).
   always_ff @(posedge clk) begin
      if (reset || state != S_CLEAR) begin
         clr_x <= '0;
         clr_y <= '0;
      end else if (clr_x == CLR_X_LAST) begin
         clr_x <= '0;
         clr_y <= clr_y + 7'd1;
      end else begin
         clr_x <= clr_x + 6'd1;
      end
   end
`else
   assign clear_pix = '0;
`endif

   assign board_pix = make_pixel(board_X, board_Y, board_colour);
   assign piece_pix = make_pixel(piece_X, piece_Y, piece_colour);

   // BOARD exit decode; the first two cycles mask a stale finished flag.
   always_comb begin
      board_seen = board_finished && (board_cnt >= 12'd2);
      board_to   = (board_cnt == BOARD_LAST) && !board_seen;
      board_exit = board_seen || (board_cnt == BOARD_LAST);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= next_state;
   end

   // Next-state logic.
   always_comb begin
      next_state = state;
      unique case (state)
         S_IDLE: begin
            if (start) begin
`ifdef DRAW_SCHED_CLEAR_EN
               next_state = S_CLEAR;
`else
               next_state = S_BOARD_KICK;
`endif
            end
         end
`ifdef DRAW_SCHED_CLEAR_EN
         S_CLEAR:      if (clr_last) next_state = S_BOARD_KICK;
`endif
         S_BOARD_KICK: next_state = S_BOARD;
         S_BOARD:      if (board_exit) next_state = S_PIECE;
         S_PIECE:      if (piece_cnt == PIECE_LAST) next_state = S_FIN;
         S_FIN:        next_state = S_IDLE;
         default:      next_state = S_IDLE;
      endcase
   end

   // Output logic: next values of the registered outputs plus the port select.
   // Outputs are decoded from next_state so they line up with the state they
   // describe; the port select is decoded from the current state because the
   // mux register adds the one-cycle pixel lag.
   always_comb begin
      board_enable_d = (next_state == S_BOARD_KICK);
      // piece_run covers the first PIECE_CYCLES cycles of PIECE, low on the last.
      piece_run_d    = (next_state == S_PIECE) &&
                       ((state != S_PIECE) || (piece_cnt < PIECE_RUN_LAST));
      busy_d         = (next_state != S_IDLE);
      done_d         = (next_state == S_FIN);
      timeout_d      = timeout;
      if (state == S_IDLE && start)       timeout_d = 1'b0;
      else if (state == S_BOARD && board_to) timeout_d = 1'b1;

      sel = SRC_NONE;
      unique case (state)
`ifdef DRAW_SCHED_CLEAR_EN
         S_CLEAR: sel = SRC_CLEAR;
`endif
         // The exit cycle writes nothing, so a finishing drawer's last beat is dropped.
         S_BOARD: sel = board_exit ? SRC_NONE : SRC_BOARD;
         // Last PIECE cycle still samples the drawer's registered final pixel,
         // which therefore reaches the port during FIN.
         S_PIECE: sel = SRC_PIECE;
         default: sel = SRC_NONE;
      endcase
   end

   // Per-state cycle counters; zero whenever the state is left or not active.
   always_ff @(posedge clk) begin
      if (reset) begin
         board_cnt <= '0;
         piece_cnt <= '0;
      end else begin
         board_cnt <= (state == S_BOARD && next_state == S_BOARD) ? board_cnt + 12'd1 : '0;
         piece_cnt <= (state == S_PIECE && next_state == S_PIECE) ? piece_cnt + PC_W'(1) : '0;
      end
   end

   // Registered control outputs; reset stops both drawers on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         board_enable <= 1'b0;
         piece_run    <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         timeout      <= 1'b0;
      end else begin
         board_enable <= board_enable_d;
         piece_run    <= piece_run_d;
         busy         <= busy_d;
         done         <= done_d;
         timeout      <= timeout_d;
      end
   end

   draw_port_mux u_mux (
      .clk         (clk),
      .reset       (reset),
      .sel         (sel),
      .clear_pix   (clear_pix),
      .board_pix   (board_pix),
      .piece_pix   (piece_pix),
      .piece_write (piece_writeEn),
      .x           (X),
      .y           (Y),
      .colour      (colour),
      .write       (writeEn)
   );

endmodule
